// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink-rate control stage: press-state
// encoding and the width/maximum of the blink-rate index.
package blink_pkg;

    localparam int RATE_W = 2;
    localparam logic [RATE_W-1:0] RATE_MAX = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } press_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for an active-low push button.
// key_level follows the synchronized key only after it has differed from the
// current level for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;

    // Invert and synchronize the raw key into the clk domain (1 = pressed).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement; accept the new level on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            key_level <= 1'b0;
        end else if (sync2 != key_level) begin
            if (db_cnt == DB_LAST) begin
                key_level <= sync2;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Blink-rate controller: classifies debounced presses as short (advance the
// rate, wrapping) or long (return to the slowest rate) and emits a one-cycle
// tick every 2^(CNT_W-rate) cycles. Any rate write restarts the prescaler so
// the first tick after a change lands one full new period later.
module blink_rate_ctrl
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_n,
    output logic              tick,
    output logic [RATE_W-1:0] rate,
    output logic              key_level,
    output logic              short_press,
    output logic              long_press
);

    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ALL   = {CNT_W{1'b1}};

    press_state_t      state;
    press_state_t      state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              key_level_q;
    logic              level_rise;
    logic              level_fall;
    logic              short_nxt;
    logic              long_nxt;
    logic              rate_wr;
    logic [RATE_W-1:0] rate_nxt;
    logic [CNT_W-1:0]  pcnt;
    logic [CNT_W-1:0]  limit;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .key_level (key_level)
    );

    assign level_rise = key_level & ~key_level_q;
    assign level_fall = ~key_level & key_level_q;
    assign limit      = CNT_ALL >> rate;

    // Previous debounced level, for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level_q <= 1'b0;
        end else begin
            key_level_q <= key_level;
        end
    end

    // Press FSM state, hold counter, registered press pulses and the rate index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            rate        <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            short_press <= short_nxt;
            long_press  <= long_nxt;
            if (rate_wr) begin
                rate <= rate_nxt;
            end
        end
    end

    // Next-state logic; a release in the threshold cycle is still a short press.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        short_nxt    = 1'b0;
        long_nxt     = 1'b0;
        rate_wr      = 1'b0;
        rate_nxt     = rate;
        case (state)
            IDLE: begin
                if (level_rise) begin
                    state_nxt    = HELD;
                    hold_cnt_nxt = '0;
                end
            end
            HELD: begin
                if (level_fall) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                    rate_wr   = 1'b1;
                    rate_nxt  = (rate == RATE_MAX) ? '0 : rate + 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                    rate_wr   = 1'b1;
                    rate_nxt  = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (level_fall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Prescaler: a rate write restarts the count and suppresses that cycle's tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (rate_wr) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt == limit) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Bench for blink_rate_ctrl with small parameters. A time-based model
// (debounce windows over the key history, press durations, tick anchors)
// is compared against the DUT after every clock edge; directed scenarios add
// hand-computed literal expectations on edge numbers and counts.
module tb_blink_rate_ctrl;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int CW   = 4;
    localparam int HIST = 4096;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       key_n = 1'b1;
    logic       tick;
    logic [1:0] rate;
    logic       key_level;
    logic       short_press;
    logic       long_press;

    blink_rate_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LONG),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .tick        (tick),
        .rate        (rate),
        .key_level   (key_level),
        .short_press (short_press),
        .long_press  (long_press)
    );

    // Clock
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int printed = 0;
    int edge_n  = 0;

    // Model state
    bit kn_a [HIST];
    bit lvl_a[HIST];
    int last_rst   = 0;
    int anchor     = 0;
    int held_start = 0;
    bit in_press   = 0;
    bit long_done  = 0;
    int m_rate     = 0;
    bit e_tick     = 0;
    bit e_short    = 0;
    bit e_long     = 0;

    // Observations of the DUT, indexed by edge number
    int tick_q[$];
    int short_cnt       = 0;
    int long_cnt        = 0;
    int lvl_ones        = 0;
    int last_short_edge = -1;
    int last_long_edge  = -1;
    int lvl_rise_edge   = -1;
    bit prev_kl         = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (printed < 40) begin
                $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
                printed++;
            end
        end
    endtask

    // Synchronized key seen at edge j: raw key two edges earlier, 0 near reset.
    function automatic bit ks(input int j);
        if (j - 2 > last_rst) return ~kn_a[j-2];
        return 1'b0;
    endfunction

    function automatic int first_tick_after(input int e);
        foreach (tick_q[i]) begin
            if (tick_q[i] > e) return tick_q[i];
        end
        return -1;
    endfunction

    task automatic model_step(input int e, input bit r, input bit kn);
        bit p1, p2, ok, rise, fall, wr;
        int old_rate;
        kn_a[e] = kn;
        if (r) begin
            last_rst  = e;
            lvl_a[e]  = 1'b0;
            in_press  = 1'b0;
            long_done = 1'b0;
            m_rate    = 0;
            anchor    = e;
            e_tick    = 1'b0;
            e_short   = 1'b0;
            e_long    = 1'b0;
        end else begin
            p1 = lvl_a[e-1];
            p2 = lvl_a[e-2];
            ok = 1'b1;
            for (int j = e - DB + 1; j <= e; j++) begin
                if (j <= last_rst || ks(j) == p1) ok = 1'b0;
            end
            lvl_a[e] = ok ? ~p1 : p1;
            rise     = p1 && !p2;
            fall     = !p1 && p2;
            old_rate = m_rate;
            wr       = 1'b0;
            e_short  = 1'b0;
            e_long   = 1'b0;
            if (!in_press && rise) begin
                in_press   = 1'b1;
                long_done  = 1'b0;
                held_start = e;
            end else if (in_press && !long_done && fall) begin
                e_short  = 1'b1;
                m_rate   = (m_rate + 1) % 4;
                wr       = 1'b1;
                in_press = 1'b0;
            end else if (in_press && !long_done && (e - held_start == LONG)) begin
                e_long    = 1'b1;
                m_rate    = 0;
                wr        = 1'b1;
                long_done = 1'b1;
            end else if (in_press && long_done && fall) begin
                in_press = 1'b0;
            end
            if (wr) begin
                e_tick = 1'b0;
                anchor = e;
            end else if (e - anchor == (1 << (CW - old_rate))) begin
                e_tick = 1'b1;
                anchor = e;
            end else begin
                e_tick = 1'b0;
            end
        end
    endtask

    // One clock: sample inputs at the edge, compare #1 later, return at negedge.
    task automatic step();
        bit r, kn;
        @(posedge clk);
        edge_n++;
        r  = rst;
        kn = key_n;
        if (edge_n >= HIST) begin
            $display("FAIL history_overflow at edge %0d: got %0d expected below %0d", edge_n, edge_n, HIST);
            $fatal(1, "history overflow");
        end
        #1;
        model_step(edge_n, r, kn);
        check("tick", tick, e_tick);
        check("rate", rate, m_rate);
        check("key_level", key_level, lvl_a[edge_n]);
        check("short_press", short_press, e_short);
        check("long_press", long_press, e_long);
        if (tick) tick_q.push_back(edge_n);
        if (short_press) begin
            short_cnt++;
            last_short_edge = edge_n;
        end
        if (long_press) begin
            long_cnt++;
            last_long_edge = edge_n;
        end
        if (key_level) lvl_ones++;
        if (key_level && !prev_kl) lvl_rise_edge = edge_n;
        prev_kl = key_level;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
    endtask

    task automatic short_tap(input int low_cycles, input int settle);
        key_n = 1'b0;
        run(low_cycles);
        key_n = 1'b1;
        run(settle);
    endtask

    int r0, s0, l0, o0, u, t1, t2, x0;
    int exp_rates[4] = '{1, 2, 3, 0};
    int periods[4]   = '{8, 4, 2, 16};

    initial begin
        // 1: reset and idle
        key_n = 1'b1;
        do_reset();
        r0 = edge_n;
        s0 = short_cnt;
        l0 = long_cnt;
        check("rst_tick", tick, 0);
        check("rst_rate", rate, 0);
        check("rst_key_level", key_level, 0);
        check("rst_short", short_press, 0);
        check("rst_long", long_press, 0);
        run(40);
        check("idle_tick1", first_tick_after(r0), r0 + 16);
        check("idle_tick2", first_tick_after(r0 + 16), r0 + 32);
        check("idle_rate", rate, 0);
        check("idle_no_press", (short_cnt - s0) + (long_cnt - l0), 0);

        // 2: glitch rejection
        do_reset();
        o0 = lvl_ones;
        short_tap(3, 12);
        check("glitch_level", lvl_ones - o0, 0);
        check("glitch_rate", rate, 0);

        // 3: short press
        do_reset();
        r0 = edge_n;
        s0 = short_cnt;
        short_tap(10, 30);
        check("short_count", short_cnt - s0, 1);
        check("short_rate", rate, 1);
        check("short_edge", last_short_edge, r0 + 17);
        t1 = first_tick_after(last_short_edge);
        check("short_first_tick", t1 - last_short_edge, 8);
        check("short_period", first_tick_after(t1) - t1, 8);

        // 4: wrap through all rates
        do_reset();
        for (int i = 0; i < 4; i++) begin
            short_tap(10, 45);
            check("wrap_rate", rate, exp_rates[i]);
            u  = last_short_edge;
            t1 = first_tick_after(u);
            t2 = first_tick_after(t1);
            check("wrap_first_tick", t1 - u, periods[i]);
            check("wrap_period", t2 - t1, periods[i]);
        end

        // 5: long press from rate 2
        do_reset();
        short_tap(10, 30);
        short_tap(10, 30);
        check("long_setup_rate", rate, 2);
        s0 = short_cnt;
        l0 = long_cnt;
        x0 = edge_n + 1;
        short_tap(40, 20);
        check("long_count", long_cnt - l0, 1);
        check("long_no_short", short_cnt - s0, 0);
        check("long_rate", rate, 0);
        check("long_after_rise", last_long_edge - lvl_rise_edge, 21);
        check("long_edge", last_long_edge, x0 + 26);

        // 6: rate write collides with a tick
        do_reset();
        r0 = edge_n;
        run(9);
        short_tap(16, 30);
        check("collide_old_tick", first_tick_after(r0), r0 + 16);
        check("collide_write_edge", last_short_edge, r0 + 32);
        check("collide_next_tick", first_tick_after(r0 + 16), r0 + 40);
        check("collide_rate", rate, 1);

        // 7: reset mid-press, key still held afterwards
        do_reset();
        key_n = 1'b0;
        run(12);
        do_reset();
        s0 = short_cnt;
        l0 = long_cnt;
        run(10);
        key_n = 1'b1;
        run(20);
        check("midrst_short", short_cnt - s0, 1);
        check("midrst_long", long_cnt - l0, 0);
        check("midrst_rate", rate, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_rate_ctrl.md
# blink_rate_ctrl

Upstream control stage for the board LED blinker. Debounces one active-low push button (DE0 KEY) and classifies presses as short or long. Owns a 2-bit blink-rate index and emits a single-cycle `tick` at the selected rate. The downstream LED toggler flips its output once per `tick` and keeps no counter of its own.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- `LONG_CYCLES`, default 50000000: cycles a debounced press must be held to count as a long press (1 s).
- `CNT_W`, default 24: prescaler width. The base tick period is 2^CNT_W cycles.

Ports:
- `clk`  in  1: single clock, all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `key_n`  in  1: raw push button, asynchronous, 0 = pressed.
- `tick`  out  1: one-cycle pulse at the selected rate.
- `rate`  out  2: current rate index, 0..3.
- `key_level`  out  1: debounced key state, 1 = pressed.
- `short_press`  out  1: one-cycle pulse when a short press is accepted.
- `long_press`  out  1: one-cycle pulse when a long press is accepted.

## Operation
- **Synchronizer:**
  - `key_n` is inverted and passed through 2 flip-flops, giving `key_s`.
  - Both flip-flops reset to 0 (released).
- **Debounce:**
  - `db_cnt` counts while `key_s != key_level` and clears whenever they are equal.
  - When `db_cnt == DEBOUNCE_CYCLES-1` and the two still differ, `key_level <= key_s` and `db_cnt <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` never changes `key_level`.
- **Press FSM**, with states IDLE, HELD and LONG:
  - IDLE -> HELD on a rising edge of `key_level`; `hold_cnt <= 0`.
  - In HELD, `hold_cnt` increments every cycle.
  - HELD -> IDLE on a falling edge of `key_level`: `short_press` pulses and `rate <= rate+1`, wrapping 3 -> 0.
  - HELD -> LONG when `hold_cnt == LONG_CYCLES-1`: `long_press` pulses and `rate <= 0`.
  - LONG -> IDLE on a falling edge of `key_level`, with no pulse and no rate change.
  - If the release edge and the long-press threshold fall in the same cycle, the release wins and the press is short.
- **Prescaler:**
  - `limit = ({CNT_W{1'b1}} >> rate)`, so the period is 2^(CNT_W-rate) cycles.
  - `pcnt` increments every cycle. When `pcnt == limit`, `tick` is 1 for that cycle's registered output and `pcnt <= 0`.
  - In any cycle where `rate` is written, `pcnt <= 0` and no tick is issued, even if `pcnt == limit` in that same cycle.
  - After a rate change, the first tick arrives exactly one new period later.
- **Reset values:**
  - Outputs: `tick`=0, `rate`=0, `key_level`=0, `short_press`=0, `long_press`=0.
  - Internal: state = IDLE, and all counters = 0.
  - Asserting `rst` mid-press aborts the press. A key still held after reset is debounced afresh and counts as a new press.

## Timing
- A clean `key_n` edge reaches `key_level` after 2 + `DEBOUNCE_CYCLES` cycles.
- `short_press` and `long_press` are registered. Each pulses in the cycle after the FSM transition condition.
- The `rate` update lands on the same edge as the pulse.
- `tick` is registered and its high time is exactly 1 cycle. Consecutive ticks are exactly 2^(CNT_W-rate) cycles apart when `rate` is stable.
- `rst` takes effect on the next rising edge of `clk`. All outputs read their reset values in the cycle after `rst` is sampled high.

## Structure
- **Shared package `blink_pkg`:**
  - Press-state encoding: IDLE=0, HELD=1, LONG=2, with a 2-bit state width.
  - `RATE_W`=2 and `RATE_MAX`=3.
- **Sub-module `key_debounce`:**
  - Contains the synchronizer and the debounce counter.
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst`, `key_n`, `key_level`.
- The top level holds the press FSM, the rate register and the prescaler.

## Test plan
Bench parameters for every scenario: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `CNT_W`=4.

1. **Reset and idle:** hold `rst` for 3 cycles, then release with `key_n`=1 → ticks every 16 cycles, `rate`=0, no press pulses.
2. **Glitch rejection:** a `key_n` low pulse of 3 cycles → `key_level` stays 0 and `rate` stays 0.
3. **Short press:** `key_n` low for 10 cycles, then high → exactly one `short_press` and `rate`=1. The next tick comes 8 cycles after the rate update; later ticks are 8 apart.
4. **Wrap:** four short presses → `rate` sequence 1, 2, 3, 0, with periods 8, 4, 2, 16.
5. **Long press:** set `rate`=2, then hold `key_n` low for 40 cycles → one `long_press` after 20 debounced-held cycles, `rate`=0, no `short_press` on release.
6. **Rate change collides with tick:** issue a short press timed so `rate` is written in the cycle `pcnt==limit` → no tick that cycle, and the next tick arrives one full new period later.
